// File: rtl/mem_stage_pkg.sv
// Shared micro-op definitions for the memory stage: access kinds, sizes and FSM states.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        MK_NONE  = 2'd0,
        MK_LOAD  = 2'd1,
        MK_STORE = 2'd2
    } mem_kind_t;

    typedef enum logic [1:0] {
        SZ_1B = 2'd0,
        SZ_2B = 2'd1,
        SZ_4B = 2'd2,
        SZ_8B = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_WB   = 2'd3
    } mem_state_t;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: selects the addressed bytes out of an 8-byte memory word and extends them.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [63:0] rdata_i,
    input  logic [2:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        sext_i,
    output logic [63:0] data_o
);

    logic [63:0] shifted;

    assign shifted = rdata_i >> {offset_i, 3'b000};

    always_comb begin
        data_o = shifted;
        unique case (mem_size_t'(size_i))
            SZ_1B: data_o = {{56{sext_i & shifted[7]}},  shifted[7:0]};
            SZ_2B: data_o = {{48{sext_i & shifted[15]}}, shifted[15:0]};
            SZ_4B: data_o = {{32{sext_i & shifted[31]}}, shifted[31:0]};
            SZ_8B: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: captures one execute result at a time, performs the data memory access, and
// presents a single-cycle writeback. Execute is stalled whenever the stage is not idle.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              exe_valid,
    input  logic [1:0]        exe_kind,
    input  logic [1:0]        exe_size,
    input  logic              exe_sext,
    input  logic [ADDR_W-1:0] exe_addr,
    input  logic [DATA_W-1:0] exe_data,
    input  logic [3:0]        exe_dest,
    input  logic [63:0]       exe_rflags,
    output logic              mem_blocked,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [7:0]        dmem_be,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [3:0]        wb_dest,
    output logic [DATA_W-1:0] wb_data,
    output logic [63:0]       wb_rflags,
    output logic              wb_err
);

    mem_state_t        state_q;
    mem_kind_t         kind_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [3:0]        dest_q;
    logic [63:0]       rflags_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              wb_we_q;
    logic              wb_err_q;

    logic              exe_misalign;
    logic              in_req;
    logic [8:0]        be_mask;
    logic [DATA_W-1:0] ld_data;

    // An access that would spill past the 8-byte word is reported instead of issued.
    assign exe_misalign = ({1'b0, exe_addr[2:0]} + size_bytes(exe_size)) > 4'd8;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            kind_q    <= MK_NONE;
            size_q    <= '0;
            sext_q    <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            dest_q    <= '0;
            rflags_q  <= '0;
            wb_data_q <= '0;
            wb_we_q   <= 1'b0;
            wb_err_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: if (exe_valid) begin
                    kind_q    <= mem_kind_t'(exe_kind);
                    size_q    <= exe_size;
                    sext_q    <= exe_sext;
                    addr_q    <= exe_addr;
                    data_q    <= exe_data;
                    dest_q    <= exe_dest;
                    rflags_q  <= exe_rflags;
                    wb_data_q <= '0;
                    wb_we_q   <= 1'b0;
                    wb_err_q  <= 1'b0;
                    unique case (mem_kind_t'(exe_kind))
                        MK_LOAD, MK_STORE: begin
                            if (exe_misalign) begin
                                wb_err_q <= 1'b1;
                                state_q  <= ST_WB;
                            end else begin
                                state_q  <= ST_REQ;
                            end
                        end
                        default: begin
                            wb_data_q <= DATA_W'(exe_addr);
                            wb_we_q   <= 1'b1;
                            state_q   <= ST_WB;
                        end
                    endcase
                end
                ST_REQ: if (dmem_ready) begin
                    // Read data accepted alongside ready is not trusted; WAIT picks up the real beat.
                    state_q <= (kind_q == MK_LOAD) ? ST_WAIT : ST_WB;
                end
                ST_WAIT: if (dmem_rvalid) begin
                    wb_data_q <= ld_data;
                    wb_we_q   <= 1'b1;
                    state_q   <= ST_WB;
                end
                ST_WB: state_q <= ST_IDLE;
            endcase
        end
    end

    load_align u_load_align (
        .rdata_i  (dmem_rdata),
        .offset_i (addr_q[2:0]),
        .size_i   (size_q),
        .sext_i   (sext_q),
        .data_o   (ld_data)
    );

    assign mem_blocked = (state_q != ST_IDLE);
    assign in_req      = (state_q == ST_REQ);
    assign be_mask     = (9'd1 << size_bytes(size_q)) - 9'd1;

    assign dmem_req   = in_req;
    assign dmem_we    = in_req & (kind_q == MK_STORE);
    assign dmem_addr  = in_req ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
    assign dmem_be    = in_req ? (be_mask[7:0] << addr_q[2:0]) : 8'h00;
    assign dmem_wdata = in_req ? (data_q << {addr_q[2:0], 3'b000}) : '0;

    assign wb_valid  = (state_q == ST_WB);
    assign wb_we     = wb_valid & wb_we_q;
    assign wb_err    = wb_valid & wb_err_q;
    assign wb_dest   = wb_valid ? dest_q    : '0;
    assign wb_data   = wb_valid ? wb_data_q : '0;
    assign wb_rflags = wb_valid ? rflags_q  : '0;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed cases, randomized ops against a byte-level model,
// and a reset-during-WAIT scenario.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        exe_valid = 1'b0;
    logic [1:0]  exe_kind = '0;
    logic [1:0]  exe_size = '0;
    logic        exe_sext = 1'b0;
    logic [63:0] exe_addr = '0;
    logic [63:0] exe_data = '0;
    logic [3:0]  exe_dest = '0;
    logic [63:0] exe_rflags = '0;
    logic        mem_blocked;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [7:0]  dmem_be;
    logic [63:0] dmem_wdata;
    logic        dmem_ready = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [63:0] dmem_rdata = '0;
    logic        wb_valid;
    logic        wb_we;
    logic [3:0]  wb_dest;
    logic [63:0] wb_data;
    logic [63:0] wb_rflags;
    logic        wb_err;

    mem_stage #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .exe_valid(exe_valid), .exe_kind(exe_kind), .exe_size(exe_size), .exe_sext(exe_sext),
        .exe_addr(exe_addr), .exe_data(exe_data), .exe_dest(exe_dest), .exe_rflags(exe_rflags),
        .mem_blocked(mem_blocked),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data),
        .wb_rflags(wb_rflags), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  dest;
        logic [63:0] data;
        logic        we;
        logic        err;
        logic [63:0] rflags;
    } wb_exp_t;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  be;
        logic [63:0] wdata;
        logic        we;
        logic [63:0] rdata;
        int          rdly;
        int          vdly;
    } mem_exp_t;

    wb_exp_t  wb_q[$];
    mem_exp_t mem_q[$];
    int tests = 0;
    int fails = 0;
    bit resp_en = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic flag(input string nm);
        tests++;
        fails++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    // Byte-by-byte model of a load: pick n bytes starting at off, then extend.
    function automatic logic [63:0] ld_model(input logic [63:0] rd, input int off, input int n,
                                             input bit sx);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
        if (sx && v[8*n-1]) for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic issue(input logic [1:0] kind, input logic [1:0] size, input bit sext,
                         input logic [63:0] addr, input logic [63:0] data, input logic [3:0] dest,
                         input logic [63:0] rflags, input logic [63:0] rdata, input int rdly);
        int n, off, k;
        wb_exp_t  w;
        mem_exp_t m;
        n   = 1 << size;
        off = int'(addr[2:0]);
        @(negedge clk);
        k = 0;
        while (mem_blocked && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k == 200) flag("issue_wait_timeout");
        w.dest = dest; w.rflags = rflags; w.data = '0; w.we = 1'b0; w.err = 1'b0;
        if (kind == MK_NONE) begin
            w.data = addr; w.we = 1'b1;
        end else if (off + n > 8) begin
            w.err = 1'b1;
        end else begin
            m.addr  = addr & ~64'h7;
            m.be    = '0;
            for (int i = 0; i < n; i++) m.be[off+i] = 1'b1;
            m.wdata = data << (8*off);
            m.we    = (kind == MK_STORE);
            m.rdata = rdata;
            m.rdly  = rdly;
            m.vdly  = int'($urandom_range(1, 3));
            mem_q.push_back(m);
            if (kind == MK_LOAD) begin
                w.data = ld_model(rdata, off, n, sext);
                w.we   = 1'b1;
            end
        end
        wb_q.push_back(w);
        exe_valid = 1'b1; exe_kind = kind; exe_size = size; exe_sext = sext;
        exe_addr = addr; exe_data = data; exe_dest = dest; exe_rflags = rflags;
        @(negedge clk);
        // Junk on the execute bus while blocked must not disturb the captured op.
        exe_valid = 1'b0; exe_kind = 2'($urandom); exe_size = 2'($urandom);
        exe_sext = 1'($urandom); exe_addr = {$urandom, $urandom};
        exe_data = {$urandom, $urandom}; exe_dest = 4'($urandom); exe_rflags = {$urandom, $urandom};
    endtask

    // Memory responder: checks each request, holds it for rdly cycles, then returns data.
    initial begin
        mem_exp_t m;
        forever begin
            @(negedge clk);
            if (resp_en && reset_n && dmem_req) begin
                if (mem_q.size() == 0) begin
                    flag("unexpected_dmem_req");
                    dmem_ready = 1'b1;
                    @(negedge clk);
                    dmem_ready = 1'b0;
                end else begin
                    m = mem_q.pop_front();
                    chk("dmem_addr", dmem_addr, m.addr);
                    chk("dmem_be", {56'd0, dmem_be}, {56'd0, m.be});
                    chk("dmem_wdata", dmem_wdata, m.wdata);
                    chk("dmem_we", {63'd0, dmem_we}, {63'd0, m.we});
                    for (int i = 0; i < m.rdly; i++) begin
                        @(negedge clk);
                        chk("dmem_hold", {dmem_req, dmem_we, dmem_be, dmem_addr ^ dmem_wdata},
                            {1'b1, m.we, m.be, m.addr ^ m.wdata});
                    end
                    dmem_ready  = 1'b1;
                    dmem_rvalid = 1'($urandom);
                    dmem_rdata  = {$urandom, $urandom};
                    @(negedge clk);
                    dmem_ready  = 1'b0;
                    dmem_rvalid = 1'b0;
                    if (!m.we) begin
                        for (int i = 1; i < m.vdly; i++) @(negedge clk);
                        dmem_rvalid = 1'b1;
                        dmem_rdata  = m.rdata;
                        @(negedge clk);
                        dmem_rvalid = 1'b0;
                    end
                end
            end
        end
    end

    // Writeback monitor.
    initial begin
        wb_exp_t e;
        forever begin
            @(negedge clk);
            if (wb_valid) begin
                if (wb_q.size() == 0) begin
                    flag("unexpected_wb_valid");
                end else begin
                    e = wb_q.pop_front();
                    chk("wb_dest", {60'd0, wb_dest}, {60'd0, e.dest});
                    chk("wb_data", wb_data, e.data);
                    chk("wb_we", {63'd0, wb_we}, {63'd0, e.we});
                    chk("wb_err", {63'd0, wb_err}, {63'd0, e.err});
                    chk("wb_rflags", wb_rflags, e.rflags);
                    chk("blocked_in_wb", {63'd0, mem_blocked}, 64'd1);
                end
            end else begin
                chk("wb_idle_zero", {60'd0, wb_we, wb_err, 2'b00} | wb_data | wb_rflags |
                    {60'd0, wb_dest}, 64'd0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic drain();
        int k = 0;
        while ((wb_q.size() != 0 || mem_q.size() != 0 || mem_blocked) && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (k == 500) flag("drain_timeout");
    endtask

    initial begin
        int n;
        logic [63:0] a;
        logic [1:0]  kind, size;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {60'd0, mem_blocked, dmem_req, wb_valid, dmem_we} | {56'd0, dmem_be},
            64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", {63'd0, mem_blocked}, 64'd0);

        // NONE: one-cycle latency, blocked for one cycle.
        issue(MK_NONE, 2'd0, 1'b0, 64'h1234, 64'h0, 4'd3, 64'h55, 64'h0, 0);
        chk("none_latency", {63'd0, wb_valid}, 64'd1);
        chk("none_data", wb_data, 64'h1234);
        @(negedge clk);
        chk("none_unblock", {63'd0, mem_blocked}, 64'd0);

        issue(MK_LOAD, 2'd1, 1'b1, 64'h1006, 64'h0, 4'd5, 64'hA, 64'h8000_0000_0000_0000, 2);
        issue(MK_STORE, 2'd2, 1'b0, 64'h2004, 64'hAABBCCDD, 4'd6, 64'hB, 64'h0, 1);
        drain();

        // Misaligned 8-byte load: error on the next cycle, no memory request.
        issue(MK_LOAD, 2'd3, 1'b0, 64'h3003, 64'h0, 4'd7, 64'hC, 64'h0, 0);
        chk("misalign_latency", {62'd0, wb_valid, wb_err}, 64'd3);

        // Back-to-back NONE ops: one every two cycles.
        for (int i = 0; i < 4; i++) begin
            issue(MK_NONE, 2'($urandom), 1'b0, {$urandom, $urandom}, 64'h0, 4'(i), 64'(i), 64'h0, 0);
            chk("b2b_wb", {63'd0, wb_valid}, 64'd1);
        end

        for (int i = 0; i < 300; i++) begin
            kind = 2'($urandom_range(0, 2));
            size = 2'($urandom);
            n    = 1 << size;
            a    = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a[2:0] = 3'($urandom_range(0, 8 - n));
            issue(kind, size, 1'($urandom), a, {$urandom, $urandom}, 4'($urandom),
                  {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 3)));
        end
        drain();

        // Reset while waiting for load data; a late rvalid must not produce a writeback.
        resp_en = 1'b0;
        issue(MK_LOAD, 2'd3, 1'b0, 64'h4000, 64'h0, 4'd9, 64'hD, 64'h0123_4567_89AB_CDEF, 0);
        chk("rst_req_seen", {63'd0, dmem_req}, 64'd1);
        dmem_ready = 1'b1;
        @(negedge clk);
        dmem_ready = 1'b0;
        chk("rst_in_wait", {62'd0, mem_blocked, dmem_req}, 64'd2);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_outputs", {60'd0, mem_blocked, dmem_req, wb_valid, wb_we} |
            {56'd0, dmem_be} | dmem_addr | wb_data, 64'd0);
        wb_q.delete();
        mem_q.delete();
        @(negedge clk);
        #2 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dmem_rvalid = 1'b1;
            dmem_rdata  = {$urandom, $urandom};
        end
        @(negedge clk);
        dmem_rvalid = 1'b0;
        chk("rst_no_wb_blocked", {62'd0, mem_blocked, wb_valid}, 64'd0);
        repeat (3) @(negedge clk);
        chk("final_queues_empty", 64'(wb_q.size() + mem_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: ADDR_W, 64, address width in bits.
REQ-002 Parameter: DATA_W, 64, data width in bits; fixed at 64 for this revision.
REQ-003 Ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- exe_valid  in  1  execute result valid; driven by the execute stage's exe_mem.
- exe_kind  in  2  mem_kind_t: NONE, LOAD, STORE.
- exe_size  in  2  access size: 0 = 1 B, 1 = 2 B, 2 = 4 B, 3 = 8 B.
- exe_sext  in  1  sign-extend load data.
- exe_addr  in  64  byte address; for NONE, the result value.
- exe_data  in  64  store data.
- exe_dest  in  4  destination GPR index.
- exe_rflags  in  64  flags from execute.
- mem_blocked  out  1  stall to execute stage.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write request.
- dmem_addr  out  64  8-byte-aligned address.
- dmem_be  out  8  byte enables.
- dmem_wdata  out  64  lane-shifted store data.
- dmem_ready  in  1  request accepted this cycle.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  64  read data.
- wb_valid  out  1  writeback valid, one-cycle pulse.
- wb_we  out  1  write wb_data to GPR.
- wb_dest  out  4  GPR index.
- wb_data  out  64  writeback value.
- wb_rflags  out  64  flags carried through.
- wb_err  out  1  misaligned access.

Function
REQ-004 FSM states SHALL be IDLE, REQ, WAIT and WB.
REQ-005 mem_blocked SHALL equal (state != IDLE), decoded combinationally from state only.
REQ-006 In IDLE with exe_valid=1, all exe_* fields SHALL be captured; with exe_valid=0, nothing SHALL be captured.
REQ-007 NONE: next cycle, state SHALL be WB with wb_data=exe_addr and wb_we=1; latency 1 cycle.
REQ-008 LOAD/STORE, boundary: if addr[2:0] + bytes > 8, next state SHALL be WB with wb_err=1, wb_we=0 and no dmem_req.
REQ-009 LOAD/STORE, aligned: next state SHALL be REQ.
REQ-010 In REQ:
- dmem_req=1, held with stable addr/be/wdata/we until the cycle dmem_ready=1.
- on dmem_ready, LOAD SHALL go to WAIT; STORE SHALL go to WB with wb_we=0.
REQ-011 In WAIT, on dmem_rvalid the state SHALL go to WB with wb_data formed from dmem_rdata.
- shifted right by 8*addr[2:0] and truncated to size.
- zero-extended, or sign-extended when exe_sext=1.
- wb_we=1.
REQ-012 dmem_rvalid in the same cycle as the accepting dmem_ready SHALL be ignored; data is expected on a later cycle.
REQ-013 dmem_be SHALL be ((1<<bytes)-1) << addr[2:0]; dmem_wdata SHALL be exe_data << 8*addr[2:0]; dmem_addr SHALL be {addr[63:3], 3'b0}.
REQ-014 WB SHALL assert wb_valid for exactly one cycle, then return to IDLE; capture SHALL NOT occur in WB.
REQ-015 wb_dest and wb_rflags SHALL equal the captured values for every completion, including errors.
REQ-016 Back-to-back NONE ops SHALL complete at one per 2 cycles (IDLE, WB).
REQ-017 Outputs other than wb_*, dmem_* and mem_blocked SHALL NOT exist; wb_* SHALL be 0 whenever wb_valid=0.

Reset
REQ-018 reset_n low SHALL force IDLE immediately and hold all outputs at 0, including mid-REQ/WAIT.
REQ-019 A dmem_rvalid arriving after reset SHALL be ignored.

Structure
REQ-020 mem_kind_t, size encodings and state enum SHALL reside in the shared micro-op package.
REQ-021 Load alignment/extension SHALL be a combinational sub-module, load_align.

Verification
REQ-022 NONE, addr=0x1234, dest=3 -> wb_valid one cycle later, wb_data=0x1234, wb_we=1, mem_blocked high 1 cycle.
REQ-023 LOAD size=1, addr=0x1006, sext=1, ready after 2 cycles, rdata=0x8000_..._0000 (bytes 6..7 = 0x8000) -> dmem_be=0xC0, wb_data=0xFFFF_FFFF_FFFF_8000.
REQ-024 STORE size=2, addr=0x2004, data=0xAABBCCDD -> dmem_be=0xF0, dmem_wdata=0xAABBCCDD_00000000, wb_valid with wb_we=0.
REQ-025 LOAD size=3, addr=0x3003 -> no dmem_req, wb_err=1 next cycle.
REQ-026 reset_n low during WAIT then late rvalid -> IDLE, outputs 0, no wb_valid.
